// File: rtl/nand_sweep_checker.sv
// Exhaustive-sweep self-checker for a WIDTH-input NAND gate: walks every input
// vector, samples the gate after SETTLE cycles and records pass/fail results.
// Optional feature: define SWEEP_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module nand_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail
);

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("nand_sweep_checker: WIDTH must be 1..16");
  end
  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("nand_sweep_checker: SETTLE must be 1..255");
  end
  if (ERRW < 1 || ERRW > 16) begin : g_bad_errw
    $error("nand_sweep_checker: ERRW must be 1..16");
  end

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE);
  localparam logic [WIDTH-1:0] A_LAST      = '1;
  localparam logic [ERRW-1:0]  ERR_MAX     = '1;

  // LOAD is the single cycle between accepting start and driving vector 0.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] settle_cnt;
  logic       sample_edge;
  logic       mismatch;
  logic       last_sample;
  logic       expected_y;

  assign expected_y = ~(&a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    sample_edge = 1'b0;
    mismatch    = 1'b0;
    last_sample = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = RUN;
      end
      RUN: begin
        if (settle_cnt == 8'd1) begin
          sample_edge = 1'b1;
          mismatch    = y ^ expected_y;
`ifdef SWEEP_STOP_ON_FAIL_EN
          last_sample = (a == A_LAST) || mismatch;
`else
          last_sample = (a == A_LAST);
`endif
          if (last_sample) begin
            next_state = DONE;
          end
        end
      end
      DONE: begin
        next_state = start ? LOAD : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The last vector is recognised before incrementing, so a never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          a          <= '0;
          busy       <= 1'b1;
          pass       <= 1'b0;
          err_count  <= '0;
          fail_valid <= 1'b0;
          first_fail <= '0;
          settle_cnt <= SETTLE_LOAD;
        end
        RUN: begin
          if (sample_edge) begin
            if (mismatch) begin
              if (err_count != ERR_MAX) begin
                err_count <= err_count + ERRW'(1);
              end
              if (!fail_valid) begin
                first_fail <= a;
                fail_valid <= 1'b1;
              end
            end
            if (last_sample) begin
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (err_count == '0) && !mismatch;
              settle_cnt <= '0;
            end else begin
              a          <= a + WIDTH'(1);
              settle_cnt <= SETTLE_LOAD;
            end
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
